// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Hazard and sequencing controller for a 5-stage RISC-V pipeline. Produces the
// load-enables for the PC and the four stage registers, plus the ID/EX bubble
// and IF/ID flush controls. It resolves load-use stalls (LOAD_LAT bubbles),
// taken-branch flushes, data-memory wait states and halt. A saturating counter
// records the number of cycles in which the PC was frozen.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   id_rs1, id_rs2        source registers of the instruction in ID
//   id_use_rs1/2          the ID instruction actually reads rs1 / rs2
//   ex_op, ex_rd          opcode and destination held in ID/EX
//   branch_taken          EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready    MEM-stage data access and its completion
//   halt                  stop request (ECALL/EBREAK)
//   ena_pc .. ena_memwb   load-enables of PC and stage registers
//   bubble_idex           load a NOP into ID/EX
//   flush_ifid            load a NOP into IF/ID
//   stall_cnt             saturating count of cycles with ena_pc=0
//   halted                controller is in the HALTED state
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int         LOAD_LAT = 1,
  parameter int         CNT_W    = 16,
  parameter logic [6:0] LOAD_OP  = 7'b0000011
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [6:0]       ex_op,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt,
  output logic             ena_pc,
  output logic             ena_ifid,
  output logic             ena_idex,
  output logic             ena_exmem,
  output logic             ena_memwb,
  output logic             bubble_idex,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             halted
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    LDSTALL = 2'd2,
    HALTED  = 2'd3
  } state_t;

  // Counter preload: the hazard cycle itself is the first bubble.
  localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);

  // Enable vector order: {pc, ifid, idex, exmem, memwb}
  localparam logic [4:0] EN_ALL    = 5'b11111;
  localparam logic [4:0] EN_NONE   = 5'b00000;
  localparam logic [4:0] EN_BUBBLE = 5'b00111;

  state_t     state, state_next;
  logic [2:0] ld_cnt, ld_cnt_next;

  logic       mem_stall;
  logic       lu_hazard;

  logic [4:0] en;
  logic       bubble;
  logic       flush;

  // RUN-style decode with the mem_stall term left out; reused on the
  // MEMWAIT release cycle so a frozen branch or load-use is not dropped.
  logic [4:0] run_en;
  logic       run_bubble;
  logic       run_flush;
  logic       run_load;
  state_t     run_state;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hazard = (ex_op == LOAD_OP) && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    run_en     = EN_ALL;
    run_bubble = 1'b0;
    run_flush  = 1'b0;
    run_load   = 1'b0;
    run_state  = RUN;
    if (halt) begin
      run_en    = EN_NONE;
      run_state = HALTED;
    end else if (branch_taken) begin
      // The dependent instruction is on the wrong path, so no stall.
      run_bubble = 1'b1;
      run_flush  = 1'b1;
    end else if (lu_hazard) begin
      run_en     = EN_BUBBLE;
      run_bubble = 1'b1;
      run_load   = 1'b1;
      run_state  = (LOAD_LAT > 1) ? LDSTALL : RUN;
    end
  end

  always_comb begin
    en          = EN_NONE;
    bubble      = 1'b0;
    flush       = 1'b0;
    state_next  = state;
    ld_cnt_next = ld_cnt;
    case (state)
      RUN, MEMWAIT: begin
        if (mem_stall && !(state == RUN && halt)) begin
          // Freeze everything; halt outranks a new memory wait only in RUN.
          state_next = MEMWAIT;
        end else begin
          en         = run_en;
          bubble     = run_bubble;
          flush      = run_flush;
          state_next = run_state;
          if (run_load) begin
            ld_cnt_next = LD_INIT;
          end
        end
      end
      LDSTALL: begin
        if (!mem_stall) begin
          en          = EN_BUBBLE;
          bubble      = 1'b1;
          ld_cnt_next = ld_cnt - 3'd1;
          // Leave once this bubble brings the remaining count to zero.
          if (ld_cnt <= 3'd1) begin
            state_next = RUN;
          end
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      ld_cnt <= 3'd0;
    end else begin
      state  <= state_next;
      ld_cnt <= ld_cnt_next;
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign ena_pc      = rst_n & en[4];
  assign ena_ifid    = rst_n & en[3];
  assign ena_idex    = rst_n & en[2];
  assign ena_exmem   = rst_n & en[1];
  assign ena_memwb   = rst_n & en[0];
  assign bubble_idex = rst_n & bubble;
  assign flush_ifid  = rst_n & flush;
  assign halted      = rst_n & (state == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!ena_pc && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
